// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO read-side stream consumer.
// The optional stall timeout is controlled by ASYNC_FIFO_RD_TIMEOUT_EN in the top.
package async_fifo_pkg;

  // Default word width, shared with the FIFO itself and its bus model
  localparam int FIFO_DATA_WIDTH_DEF = 8;

  // Default width of the transfer length and the word counter
  localparam int LEN_W_DEF = 16;

  // Read-side transfer sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  // A new transfer may only begin when the sequencer is not moving data
  function automatic logic canAccept(input rd_state_e state);
    return (state == IDLE) || (state == DONE);
  endfunction

endpackage

// File: rtl/async_fifo_rd_skid.sv
// Two-entry skid buffer between the FIFO pop port and the output stream.
// Strict FIFO order; a push and a pop in the same cycle keep the fill level,
// which is what allows one word per clock when the stream is never stalled.
module async_fifo_rd_skid
  import async_fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_WIDTH_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_fill
);

  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [1:0]        r_fill;
  logic              w_pop;
  logic              w_pushOk;

  assign w_pop    = (r_fill != 2'd0) && i_ready;
  assign w_pushOk = i_push && ((r_fill != 2'd2) || w_pop);

  assign o_valid = (r_fill != 2'd0);
  assign o_data  = r_head;
  assign o_fill  = r_fill;

  // Head/tail storage: the head only moves on a pop or when an empty buffer is filled,
  // so the presented word stays stable while the consumer back-pressures
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_fill <= 2'd0;
    end else begin
      case ({w_pushOk, w_pop})
        2'b10: begin
          if (r_fill == 2'd0) begin
            r_head <= i_data;
          end else begin
            r_tail <= i_data;
          end
          r_fill <= r_fill + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_fill <= r_fill - 2'd1;
        end
        2'b11: begin
          if (r_fill == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side consumer for the async FIFO (rclk domain): pops a programmed number of
// words through a two-entry skid buffer and re-presents them on a valid/ready stream
// with a last marker. Define ASYNC_FIFO_RD_TIMEOUT_EN to add a sticky stall timeout.
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
  parameter int LEN_W           = LEN_W_DEF
`ifdef ASYNC_FIFO_RD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 1024
`endif
) (
  input  logic                       rclk,
  input  logic                       rrst_n,
  input  logic                       rempty,
  input  logic [FIFO_DATA_WIDTH-1:0] rdata,
  output logic                       rinc,
  input  logic                       start,
  input  logic [LEN_W-1:0]           len,
  output logic                       m_valid,
  output logic [FIFO_DATA_WIDTH-1:0] m_data,
  output logic                       m_last,
  input  logic                       m_ready,
  output logic                       busy,
  output logic                       done,
  output logic [LEN_W-1:0]           word_cnt
`ifdef ASYNC_FIFO_RD_TIMEOUT_EN
  ,
  output logic                       timeout
`endif
);

  rd_state_e          r_state;
  rd_state_e          w_stateNext;
  logic [LEN_W-1:0]   r_lenQ;
  logic [LEN_W-1:0]   r_issued;
  logic [LEN_W-1:0]   r_wordCnt;
  logic [1:0]         w_fill;
  logic               w_accept;
  logic               w_rinc;
  logic               w_pop;
  logic               w_lastIssue;
  logic               w_timeoutHit;
  logic               w_timeoutFlag;

  assign w_accept = start && canAccept(r_state);

  // The pop strobe depends only on registered state and rempty, never on m_ready
  assign w_rinc = (r_state == RUN) && !rempty && (r_issued < r_lenQ) && (w_fill < 2'd2);
  assign rinc   = w_rinc;

  assign w_pop       = m_valid && m_ready;
  assign w_lastIssue = w_rinc && (r_issued == (r_lenQ - LEN_W'(1)));

  async_fifo_rd_skid #(
    .DATA_W (FIFO_DATA_WIDTH)
  ) u_skid (
    .i_clk   (rclk),
    .i_rst_n (rrst_n),
    .i_push  (w_rinc),
    .i_data  (rdata),
    .o_valid (m_valid),
    .i_ready (m_ready),
    .o_data  (m_data),
    .o_fill  (w_fill)
  );

  assign m_last   = m_valid && (r_wordCnt == (r_lenQ - LEN_W'(1))) && !w_timeoutFlag;
  assign word_cnt = r_wordCnt;

`ifdef ASYNC_FIFO_RD_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [STALL_W-1:0] r_stall;
  logic               r_timeout;
  logic               w_stallCycle;

  assign w_stallCycle  = (r_state == RUN) && rempty && (r_issued < r_lenQ);
  assign w_timeoutHit  = w_stallCycle && (r_stall == STALL_W'(TIMEOUT_CYCLES - 1));
  assign w_timeoutFlag = r_timeout;
  assign timeout       = r_timeout;

  // Stall counter: counts RUN cycles starved by an empty FIFO; any pop restarts it
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else if (w_accept) begin
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else if (w_rinc) begin
      r_stall <= '0;
    end else if (w_timeoutHit) begin
      r_stall   <= '0;
      r_timeout <= 1'b1;
    end else if (w_stallCycle) begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end
`else
  assign w_timeoutHit  = 1'b0;
  assign w_timeoutFlag = 1'b0;
`endif

  // State register
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and status outputs; RUN ends on the final pop, DRAIN ends when the buffer empties
  always_comb begin
    w_stateNext = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_stateNext = (len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_lastIssue || w_timeoutHit) begin
          w_stateNext = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if ((w_fill == 2'd0) || ((w_fill == 2'd1) && w_pop)) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (w_accept) begin
          w_stateNext = (len != '0) ? RUN : DONE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Transfer bookkeeping: length latched on an accepted start, words popped, words streamed
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_lenQ    <= '0;
      r_issued  <= '0;
      r_wordCnt <= '0;
    end else if (w_accept) begin
      r_lenQ    <= len;
      r_issued  <= '0;
      r_wordCnt <= '0;
    end else begin
      if (w_rinc) begin
        r_issued <= r_issued + LEN_W'(1);
      end
      if (w_pop && (r_wordCnt < r_lenQ)) begin
        r_wordCnt <= r_wordCnt + LEN_W'(1);
      end
    end
  end

endmodule
